fetch_unit: RTL

Parametrised instruction-fetch front end for the pipelined CPU: owns the program counter, the IF/ID pipeline register, reset-vector loading and interrupt injection. It replaces the bare PC, PC mux and enable gating in the CPU wrapper with one stage that handles stall, flush and interrupt sequencing. Instruction memory port A stays outside; this block drives its address and consumes its read data.

---
 rtl/fetch_unit_pkg.sv | 6 +
 rtl/if_id_reg.sv | 16 +
 rtl/fetch_unit.sv | 82 ++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage state encoding and default vector addresses
package fetch_unit_pkg;
  typedef enum logic [1:0] {RST_VEC = 2'd0, RUN = 2'd1, INT_VEC = 2'd2} state_t;
  localparam int RESET_VEC_DEFAULT = 0;
  localparam int INT_VEC_DEFAULT = 1;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline stage register with enable and synchronous clear (clear wins)
module if_id_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, IF/ID register, reset-vector load and interrupt injection
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RESET_VEC_ADDR = RESET_VEC_DEFAULT,
  parameter int INT_VEC_ADDR = INT_VEC_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              intr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc_current,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc_plus1,
  output logic              if_id_valid,
  output logic              if_id_is_int,
  output logic              int_ack
);
  localparam int W = DATA_W + ADDR_W + 2;
  state_t state;
  logic [ADDR_W-1:0] pc, pc_plus1;
  logic intr_q, int_pending, int_edge, take_int, rearm, clr;
  logic [W-1:0] d, q;
  assign pc_plus1 = pc + ADDR_W'(1);
  assign int_edge = intr & ~intr_q;
  assign take_int = (state == RUN) & ~flush & ~stall & int_pending;
  assign rearm = (state == INT_VEC) & flush;
  assign clr = (state == RST_VEC) | flush | ((state == INT_VEC) & ~stall);
  assign imem_addr = (state == RST_VEC) ? ADDR_W'(RESET_VEC_ADDR) :
                     (state == INT_VEC) ? ADDR_W'(INT_VEC_ADDR) : pc;
  assign d = int_pending ? {DATA_W'(0), pc, 2'b11} : {imem_rdata, pc_plus1, 2'b10};
  assign pc_current = pc;
  assign {if_id_instr, if_id_pc_plus1, if_id_valid, if_id_is_int} = q;
  if_id_reg #(.W(W)) u_if_id (
    .clk (clk),
    .rstn(rstn),
    .en  (~stall),
    .clr (clr),
    .d   (d),
    .q   (q)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RST_VEC;
      pc <= '0;
      intr_q <= 1'b0;
      int_pending <= 1'b0;
      int_ack <= 1'b0;
    end else begin
      intr_q <= intr;
      int_pending <= int_edge | rearm | (int_pending & ~take_int);
      int_ack <= take_int;
      case (state)
        RST_VEC: begin
          pc <= ADDR_W'(imem_rdata);
          state <= RUN;
        end
        RUN: begin
          if (flush) pc <= branch_target;
          else if (!stall && !int_pending) pc <= pc_plus1;
          if (take_int) state <= INT_VEC;
        end
        INT_VEC: begin
          if (flush) begin
            pc <= branch_target;
            state <= RUN;
          end else if (!stall) begin
            pc <= ADDR_W'(imem_rdata);
            state <= RUN;
          end
        end
        default: state <= RST_VEC;
      endcase
    end
  end
endmodule
